// File: rtl/hazard_sequencer.sv
// Hazard/stall controller for the 5-stage pipeline: operand forwarding, load-use
// stalls, branch flushes, multi-cycle execute sequencing and a stall-cycle counter.
module hazard_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MulStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MulBusy,
  output logic             MulValid,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       state_dbg
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("hazard_sequencer: MUL_LAT must be within 2..15");
  end

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // cnt_q holds the number of BUSY cycles still to run, including the current one.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_d, valid_d;
  logic       lwstall;

  assign state_dbg = state_q;
  assign lwstall   = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = MulBusy;
    valid_d   = 1'b0;
    if (!rst) begin
      if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)      ForwardAE = 2'b10;
      else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) ForwardAE = 2'b01;
      if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)      ForwardBE = 2'b10;
      else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) ForwardBE = 2'b01;

      case (state_q)
        RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (MulStartE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            cnt_d  = CNT_LOAD;
            // With the minimum latency there are no BUSY cycles at all.
            if (MUL_LAT == 2) begin
              state_d = DONE;
              valid_d = 1'b1;
            end else begin
              state_d = BUSY;
              busy_d  = 1'b1;
            end
          end else if (lwstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      MulBusy  <= 1'b0;
      MulValid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      MulBusy  <= busy_d;
      MulValid <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallF && StallCount != '1) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed and random cycles scored against a
// cycle-indexed reference model through an expected-output queue.
module tb_hazard_sequencer;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int W       = 16;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulValid;
  logic [CNT_W-1:0] StallCount;
  logic [1:0] state_dbg;

  hazard_sequencer #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulBusy(MulBusy), .MulValid(MulValid), .StallCount(StallCount),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, br, mul;
  } stim_t;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  // Reference state: position within a multi-cycle op (-1 = none) and stall total.
  int op_cyc = -1;
  int cnt_m  = 0;

  function automatic logic [W-1:0] actual_vec();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
            MulBusy, MulValid, StallCount};
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] model_step(input stim_t s);
    logic sf, sd, se, fd, fe, fm, busy, valid, lw;
    logic [CNT_W-1:0] cnt_now;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0;
    lw = s.ld && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    if (op_cyc < 0) begin
      if (s.br) begin
        fd = 1; fe = 1;
      end else if (s.mul) begin
        op_cyc = 0;
      end else if (lw) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    // The op sits in execute for MUL_LAT cycles; all but the last are frozen.
    if (op_cyc >= 0 && op_cyc <= MUL_LAT - 2) begin
      sf = 1; sd = 1; se = 1; fm = 1;
    end
    busy    = (op_cyc >= 1 && op_cyc <= MUL_LAT - 2);
    valid   = (op_cyc == MUL_LAT - 1);
    cnt_now = CNT_W'(cnt_m);
    if (sf && cnt_m < (1 << CNT_W) - 1) cnt_m++;
    if (op_cyc >= 0) begin
      op_cyc++;
      if (op_cyc == MUL_LAT) op_cyc = -1;
    end
    return {fwd_ref(s.rs1e, s), fwd_ref(s.rs2e, s), sf, sd, se, fd, fe, fm, busy, valid, cnt_now};
  endfunction

  task automatic apply(input stim_t s);
    RS1_D = s.rs1d; RS2_D = s.rs2d; RS1_E = s.rs1e; RS2_E = s.rs2e;
    RD_E = s.rde; RD_M = s.rdm; RD_W = s.rdw;
    RegWriteM = s.rwm; RegWriteW = s.rww; ResultSrcE = s.ld;
    PCSrcE = s.br; MulStartE = s.mul;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(model_step(s));
  endtask

  task automatic check_now(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (actual_vec() !== exp) begin
          errors++;
          $display("FAIL outputs actual=%h expected=%h t=%0t", actual_vec(), exp, $time);
        end
      end
    end
  end

  initial begin
    stim_t idle, s, lu;
    idle = '0;
    lu = idle; lu.ld = 1; lu.rde = 5'd3; lu.rs2d = 5'd3;

    rst = 1'b1;
    s = idle; s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 5;
    s.ld = 1; s.rde = 3; s.rs2d = 3; s.br = 1; s.mul = 1;
    apply(s);
    #3;
    check_now("reset_outputs", actual_vec(), '0);
    check_now("reset_state", {14'd0, state_dbg}, '0);
    apply(idle);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Forwarding priority and zero-register rule
    s = idle; s.rwm = 1; s.rdm = 5; s.rww = 1; s.rdw = 5; s.rs1e = 5; s.rs2e = 5;
    drive(s);
    s.rwm = 0;  drive(s);
    s.rdw = 0;  drive(s);

    // Load-use, x0 destination, branch priority
    drive(lu);
    drive(idle);
    s = lu; s.rde = 0; drive(s);
    s = lu; s.br = 1;  drive(s);
    drive(idle);

    // Multi-cycle op with a branch during BUSY, then a load-use to prove RUN again
    s = idle; s.mul = 1; drive(s);
    s = idle; s.br = 1;  drive(s);
    drive(idle);
    drive(idle);
    drive(lu);
    drive(idle);

    // Counter saturation
    repeat (20) drive(lu);

    // Randomized traffic
    repeat (400) begin
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      s.rwm  = 1'($urandom_range(0, 1)); s.rww = 1'($urandom_range(0, 1));
      s.ld   = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 99) < 15);
      s.mul  = ($urandom_range(0, 99) < 12);
      drive(s);
    end

    // Asynchronous reset in the middle of an op
    drive(idle);
    s = idle; s.mul = 1; drive(s);
    drive(idle);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_now("async_rst_busy", {15'd0, MulBusy}, '0);
    check_now("async_rst_stalle", {15'd0, StallE}, '0);
    check_now("async_rst_count", {12'd0, StallCount}, '0);
    check_now("async_rst_state", {14'd0, state_dbg}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    op_cyc = -1;
    cnt_m  = 0;
    repeat (6) drive(idle);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check_now("queue_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
